// File: rtl/adder_error_monitor.sv
// Error monitor comparing exact and approximate adder results over a run.
// Optional ERR_MONITOR_SQ_EN adds sum_sq_ed, the sum of squared distances.
module adder_error_monitor #(
  parameter int SAMPLES_LOG2 = 10
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [16:0]               exact_sum,
  input  logic [16:0]               approx_sum,
  output logic                      busy,
  output logic                      done,
  output logic [SAMPLES_LOG2:0]     err_count,
  output logic [16+SAMPLES_LOG2:0]  sum_ed,
`ifdef ERR_MONITOR_SQ_EN
  output logic [33+SAMPLES_LOG2:0]  sum_sq_ed,
`endif
  output logic [16:0]               max_ed
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } state_t;

  state_t                    state_q;
  logic                      rdy_q;
  logic                      busy_q;
  logic                      done_q;
  logic [SAMPLES_LOG2-1:0]   cnt_q;
  logic [16:0]               ed_q;
  logic                      edv_q;
  logic [SAMPLES_LOG2:0]     err_q;
  logic [16+SAMPLES_LOG2:0]  sum_q;
  logic [16:0]               max_q;
  logic [16:0]               ed_d;
  logic                      accept;
  logic                      last;

  assign accept = in_valid & rdy_q;
  assign last   = &cnt_q;
  assign ed_d   = (exact_sum >= approx_sum) ? exact_sum - approx_sum
                                            : approx_sum - exact_sum;

`ifdef ERR_MONITOR_SQ_EN
  logic [33+SAMPLES_LOG2:0] sq_q;
  logic [33:0]              sq_d;

  assign sq_d = 34'(ed_q) * 34'(ed_q);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sq_q <= '0;
    end else if ((state_q == IDLE || state_q == DONE) && start) begin
      sq_q <= '0;
    end else if (edv_q) begin
      sq_q <= sq_q + {{SAMPLES_LOG2{1'b0}}, sq_d};
    end
  end

  assign sum_sq_ed = sq_q;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rdy_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cnt_q   <= '0;
      ed_q    <= '0;
      edv_q   <= 1'b0;
      err_q   <= '0;
      sum_q   <= '0;
      max_q   <= '0;
    end else begin
      edv_q <= accept;
      if (accept) ed_q <= ed_d;
      if (edv_q) begin
        sum_q <= sum_q + {{SAMPLES_LOG2{1'b0}}, ed_q};
        err_q <= err_q + {{SAMPLES_LOG2{1'b0}}, |ed_q};
        if (ed_q > max_q) max_q <= ed_q;
      end
      unique case (state_q)
        IDLE, DONE: begin
          if (start) begin
            state_q <= RUN;
            rdy_q   <= 1'b1;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
            cnt_q   <= '0;
            edv_q   <= 1'b0;
            err_q   <= '0;
            sum_q   <= '0;
            max_q   <= '0;
          end
        end
        RUN: begin
          if (accept) begin
            cnt_q <= cnt_q + SAMPLES_LOG2'(1);
            if (last) begin
              state_q <= DRAIN;
              rdy_q   <= 1'b0;
            end
          end
        end
        DRAIN: begin
          // last sample's distance lands in the accumulators this edge
          state_q <= DONE;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = rdy_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err_count = err_q;
  assign sum_ed    = sum_q;
  assign max_ed    = max_q;

endmodule

// File: doc/adder_error_monitor.md
ADDER_ERROR_MONITOR -- requirements
Module: adder_error_monitor

Interface
REQ-001 SHALL have parameter SAMPLES_LOG2, default 10; a run is exactly 2^SAMPLES_LOG2 samples (legal range 1..16).
REQ-002 SHALL have port clk  input  1  sole clock, rising-edge.
REQ-003 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port start  input  1  one-cycle request to begin a run.
REQ-005 SHALL have port in_valid  input  1  sample pair valid.
REQ-006 SHALL have port in_ready  output  1  block accepts a sample this cycle.
REQ-007 SHALL have port exact_sum  input  17  accurate 16-bit adder result (carry-out in bit 16).
REQ-008 SHALL have port approx_sum  input  17  approximate adder result, same format.
REQ-009 SHALL have port busy  output  1  high in RUN and DRAIN.
REQ-010 SHALL have port done  output  1  high in DONE; results final.
REQ-011 SHALL have port err_count  output  SAMPLES_LOG2+1  samples with nonzero error distance.
REQ-012 SHALL have port sum_ed  output  17+SAMPLES_LOG2  sum of error distances.
REQ-013 SHALL have port max_ed  output  17  largest error distance in run.

Function
REQ-014 Error distance ED SHALL be |exact_sum - approx_sum|, both unsigned 17-bit, result 17-bit unsigned, never wrapped.
REQ-015 FSM SHALL have states IDLE, RUN, DRAIN, DONE.
REQ-016 IDLE/DONE + start=1 SHALL clear all accumulators and sample counter and enter RUN next edge; start elsewhere SHALL be ignored.
REQ-017 in_ready SHALL be 1 only in RUN; a sample is accepted on an edge where in_valid=1 and in_ready=1; in_valid=0 cycles (gaps) SHALL not count.
REQ-018 Pipeline: accepted sample's ED SHALL be registered on the accept edge E; accumulators SHALL update on edge E+1.
REQ-019 Per accumulated sample: sum_ed += ED; err_count += (ED!=0); max_ed = max(max_ed, ED).
REQ-020 Accepting sample number 2^SAMPLES_LOG2 at edge E SHALL move RUN->DRAIN at E; DRAIN->DONE at E+1, together with final accumulator update; done=1 from E+1.
REQ-021 Accumulators SHALL be sized so no overflow occurs at maximum ED on every sample (sum_ed max = 131071*2^SAMPLES_LOG2).
REQ-022 DONE SHALL hold results and done=1 indefinitely until start or reset.
REQ-023 Results outputs SHALL be directly registered; in DONE they SHALL not change.

Reset
REQ-024 rst_n=0 at an edge SHALL force IDLE, in_ready=0, busy=0, done=0, all counts/sums/max=0, pipeline valid=0, from any state.
REQ-025 Reset mid-run SHALL discard in-flight samples; no partial result SHALL survive.

Configuration
REQ-026 Macro ERR_MONITOR_SQ_EN defined: SHALL add output sum_sq_ed (34+SAMPLES_LOG2 bits) accumulating ED*ED with identical timing, clear and reset rules as sum_ed.
REQ-027 Macro ERR_MONITOR_SQ_EN undefined: port sum_sq_ed and its multiplier SHALL not exist; all other behaviour unchanged.

Verification (SAMPLES_LOG2=2, 4 samples)
REQ-028 start, 4 pairs exact=approx=0x00123 -> err_count=0, sum_ed=0, max_ed=0, done=1 one edge after 4th accept.
REQ-029 pairs (100,97),(50,50),(10,15),(0x1FFFF,0x1FFFE) -> err_count=3, sum_ed=9, max_ed=5, sum_sq_ed=35 (SQ_EN).
REQ-030 4 pairs (0x1FFFF,0x00000) with in_valid gaps of 3 cycles -> sum_ed=524284, max_ed=131071, err_count=4, no overflow, gaps not counted.
REQ-031 rst_n=0 after 2nd accept -> next cycle IDLE, all outputs 0; later start + 4 pairs (7,4) -> sum_ed=12 only.
REQ-032 from DONE, start + 4 pairs (0,1) -> previous results cleared, sum_ed=4, max_ed=1, err_count=4; start pulsed during RUN ignored.
